// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: operand entry and operation sequencer for the calculator.
// A is captured first, then B together with the operator. Add/sub/mul
// finish in one cycle. Divide is a restoring divider that produces one
// quotient bit per cycle, MSB first.
module calc_seq_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_val,
   input  logic [1:0]       op_sel,
   input  logic             btn_enter,
   input  logic             btn_clear,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] C,
   output logic [1:0]       op_out,
   output logic [2:0]       state_out,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic             err
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_CALC = 3'd2,
      S_DIV  = 3'd3,
      S_SHOW = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0]   a_d, b_d, c_d;
   logic [1:0]         op_d;
   logic               ovf_d, done_d;
   logic [WIDTH-1:0]   rem_q, rem_d;   // partial remainder
   logic [WIDTH-1:0]   quo_q, quo_d;   // dividend shifting out, quotient shifting in
   logic [CW-1:0]      cnt_q, cnt_d;   // divide iteration index

   logic [WIDTH:0]     sum, dif, sh, trial;
   logic [2*WIDTH-1:0] prod;
   logic               qbit;

   assign state_out = state_q;
   assign busy      = (state_q == S_CALC) || (state_q == S_DIV);
   assign err       = (state_q == S_ERR);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_A;
      else      state_q <= state_d;
   end

   // Operand, result and divider registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         A      <= '0;
         B      <= '0;
         C      <= '0;
         op_out <= '0;
         ovf    <= 1'b0;
         done   <= 1'b0;
         rem_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
      end else begin
         A      <= a_d;
         B      <= b_d;
         C      <= c_d;
         op_out <= op_d;
         ovf    <= ovf_d;
         done   <= done_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         cnt_q  <= cnt_d;
      end
   end

   // Next-state and datapath decode; clear overrides everything at the end
   always_comb begin
      state_d = state_q;
      a_d     = A;
      b_d     = B;
      c_d     = C;
      op_d    = op_out;
      ovf_d   = ovf;
      done_d  = 1'b0;
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;

      sum   = {1'b0, A} + {1'b0, B};
      dif   = {1'b0, A} - {1'b0, B};
      prod  = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
      sh    = {rem_q, quo_q[WIDTH-1]};
      trial = sh - {1'b0, B};
      qbit  = ~trial[WIDTH];

      case (state_q)
         S_A: begin
            if (btn_enter) begin
               a_d     = sw_val;
               state_d = S_B;
            end
         end
         S_B: begin
            if (btn_enter) begin
               b_d     = sw_val;
               op_d    = op_sel;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            case (op_out)
               2'b00: begin
                  c_d = sum[WIDTH-1:0]; ovf_d = sum[WIDTH];
                  done_d = 1'b1; state_d = S_SHOW;
               end
               2'b01: begin
                  c_d = dif[WIDTH-1:0]; ovf_d = dif[WIDTH];
                  done_d = 1'b1; state_d = S_SHOW;
               end
               2'b10: begin
                  c_d = prod[WIDTH-1:0]; ovf_d = |prod[2*WIDTH-1:WIDTH];
                  done_d = 1'b1; state_d = S_SHOW;
               end
               default: begin
                  if (B == '0) begin
                     c_d = '0; ovf_d = 1'b0; state_d = S_ERR;
                  end else begin
                     rem_d = '0; quo_d = A; cnt_d = '0; state_d = S_DIV;
                  end
               end
            endcase
         end
         S_DIV: begin
            // Restore by simply not committing the trial subtraction
            rem_d = qbit ? trial[WIDTH-1:0] : sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], qbit};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) begin
               c_d     = {quo_q[WIDTH-2:0], qbit};
               ovf_d   = 1'b0;
               done_d  = 1'b1;
               state_d = S_SHOW;
            end
         end
         S_SHOW: begin
            // Chain: the result becomes the next A
            if (btn_enter) begin
               a_d     = C;
               b_d     = '0;
               state_d = S_B;
            end
         end
         S_ERR: begin
            if (btn_enter) begin
               a_d = '0; b_d = '0; c_d = '0; ovf_d = 1'b0;
               state_d = S_A;
            end
         end
         default: begin
            a_d = '0; b_d = '0; c_d = '0; op_d = '0; ovf_d = 1'b0;
            state_d = S_A;
         end
      endcase

      if (btn_clear) begin
         a_d     = '0;
         b_d     = '0;
         c_d     = '0;
         op_d    = '0;
         ovf_d   = 1'b0;
         done_d  = 1'b0;
         state_d = S_A;
      end
   end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: a vector table run through a scoreboard queue,
// plus hand-written sequences for chaining, busy-ignore, clear and reset.
module tb_calc_seq_ctrl;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] sw_val = '0;
   logic [1:0]   op_sel = '0;
   logic         btn_enter = 1'b0;
   logic         btn_clear = 1'b0;
   logic [W-1:0] A, B, C;
   logic [1:0]   op_out;
   logic [2:0]   state_out;
   logic         busy, done, ovf, err;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   calc_seq_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .sw_val(sw_val), .op_sel(op_sel),
      .btn_enter(btn_enter), .btn_clear(btn_clear),
      .A(A), .B(B), .C(C), .op_out(op_out), .state_out(state_out),
      .busy(busy), .done(done), .ovf(ovf), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   op;
      logic [W-1:0] c;
      logic         ovf;
      logic         err;
      int           lat;   // cycles from the B-enter cycle to done/err
      int           bsy;   // cycles with busy high
   } vec_t;

   vec_t vecs[13];
   vec_t exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press_enter(input logic [W-1:0] v, input logic [1:0] op);
      sw_val = v; op_sel = op; btn_enter = 1'b1;
      tick();
      btn_enter = 1'b0;
   endtask

   task automatic press_clear();
      btn_clear = 1'b1;
      tick();
      btn_clear = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 60) begin
         tick();
         cyc++;
      end
   endtask

   task automatic run_vec(input int idx);
      vec_t v, e;
      int   cyc, bc;
      string tag;
      v = vecs[idx];
      press_clear();
      press_enter(v.a, 2'b00);
      press_enter(v.b, v.op);
      exp_q.push_back(v);
      cyc = 1; bc = 0;
      forever begin
         if (busy) bc++;
         if (done || err || cyc >= 60) break;
         tick();
         cyc++;
      end
      e = exp_q.pop_front();
      tag = $sformatf("v%0d", idx);
      chk({tag, "_C"},    C, 32'(e.c));
      chk({tag, "_ovf"},  ovf, 32'(e.ovf));
      chk({tag, "_err"},  err, 32'(e.err));
      chk({tag, "_lat"},  cyc, e.lat);
      chk({tag, "_busy"}, bc, e.bsy);
      chk({tag, "_st"},   state_out, e.err ? 32'd5 : 32'd4);
      tick();
      chk({tag, "_done1cyc"}, done, 0);
   endtask

   initial begin
      int cyc, dcnt;

      //            a         b         op     c         ovf   err   lat bsy
      vecs[0]  = '{16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1'b0, 2,  1};
      vecs[1]  = '{16'h0003, 16'h0005, 2'b01, 16'hFFFE, 1'b1, 1'b0, 2,  1};
      vecs[2]  = '{16'h0100, 16'h0100, 2'b10, 16'h0000, 1'b1, 1'b0, 2,  1};
      vecs[3]  = '{16'h00FF, 16'h0002, 2'b10, 16'h01FE, 1'b0, 1'b0, 2,  1};
      vecs[4]  = '{16'd1000, 16'd7,    2'b11, 16'd142,  1'b0, 1'b0, 18, 17};
      vecs[5]  = '{16'h0005, 16'h0000, 2'b11, 16'h0000, 1'b0, 1'b1, 2,  1};
      vecs[6]  = '{16'h0006, 16'h0004, 2'b00, 16'h000A, 1'b0, 1'b0, 2,  1};
      vecs[7]  = '{16'h000A, 16'h0003, 2'b01, 16'h0007, 1'b0, 1'b0, 2,  1};
      vecs[8]  = '{16'hFFFF, 16'h0001, 2'b11, 16'hFFFF, 1'b0, 1'b0, 18, 17};
      vecs[9]  = '{16'h0007, 16'h0009, 2'b11, 16'h0000, 1'b0, 1'b0, 18, 17};
      vecs[10] = '{16'h8000, 16'h8000, 2'b00, 16'h0000, 1'b1, 1'b0, 2,  1};
      vecs[11] = '{16'h1234, 16'h0010, 2'b10, 16'h2340, 1'b1, 1'b0, 2,  1};
      vecs[12] = '{16'hFFFF, 16'hFFFF, 2'b11, 16'h0001, 1'b0, 1'b0, 18, 17};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", state_out, 0);
      chk("rst_A", A, 0);
      chk("rst_C", C, 0);
      chk("rst_flags", {busy, done, ovf, err}, 0);
      rst = 1'b1;
      tick();

      // Table
      for (int i = 0; i < 13; i++) begin
         run_vec(i);
         if (i == 5) begin
            // Leave the error state with enter
            press_enter(16'h0042, 2'b00);
            chk("err_exit_state", state_out, 0);
            chk("err_exit_err", err, 0);
            chk("err_exit_A", A, 0);
         end
      end

      // Enter pulses while dividing are ignored
      press_clear();
      press_enter(16'd1000, 2'b00);
      press_enter(16'd7, 2'b11);
      repeat (5) tick();
      press_enter(16'hFFFF, 2'b00);
      chk("busy_ign_state", state_out, 3);
      chk("busy_ign_B", B, 7);
      wait_done(cyc);
      chk("busy_ign_done", done, 1);
      chk("busy_ign_C", C, 142);
      chk("busy_ign_A", A, 1000);

      // Chaining
      press_clear();
      press_enter(16'd6, 2'b00);
      press_enter(16'd4, 2'b00);
      wait_done(cyc);
      chk("chain_C", C, 10);
      chk("chain_show", state_out, 4);
      press_enter(16'h0055, 2'b00);
      chk("chain_A", A, 10);
      chk("chain_B", B, 0);
      chk("chain_state", state_out, 1);
      press_enter(16'd3, 2'b10);
      wait_done(cyc);
      chk("chain_mul_C", C, 30);
      // Back to S_B, then clear and enter together: clear wins
      press_enter(16'h0001, 2'b00);
      sw_val = 16'h0009; op_sel = 2'b11;
      btn_enter = 1'b1; btn_clear = 1'b1;
      tick();
      btn_enter = 1'b0; btn_clear = 1'b0;
      chk("clr_en_state", state_out, 0);
      chk("clr_en_regs", {A, B, C, op_out, ovf}, 0);

      // Clear mid-divide: no done produced
      press_enter(16'd100, 2'b00);
      press_enter(16'd3, 2'b11);
      repeat (4) tick();
      press_clear();
      chk("clr_div_state", state_out, 0);
      dcnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (done) dcnt++;
         tick();
      end
      chk("clr_div_nodone", dcnt, 0);
      chk("clr_div_C", C, 0);

      // Asynchronous reset mid-divide
      press_enter(16'd1000, 2'b00);
      press_enter(16'd7, 2'b11);
      repeat (5) tick();
      chk("pre_rst_busy", busy, 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_state", state_out, 0);
      chk("arst_regs", {A, B, C, op_out}, 0);
      chk("arst_flags", {busy, done, ovf, err}, 0);
      #2 rst = 1'b1;
      tick();

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
